apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- APB initiator that converts a simple valid/ready command stream into single APB3 transfers and returns a response word.
- Drives the APB slave ports of peripherals such as the secure timer blocks. Used by the SoC test/debug path and by the DMA-less config sequencer to program peripheral registers.
- Handles pready wait states and pslverr. Includes a wait-state watchdog so a hung slave cannot stall the bus forever.

Parameters:
ADDR_W, 32, width of cmd_addr and paddr
DATA_W, 32, width of write/read data
TIMEOUT_CYC, 255, max consecutive ACCESS cycles with pready=0 before abort; 0 disables the watchdog

Ports:
pclk  input  1  bus clock; all logic on rising edge
preset  input  1  asynchronous active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_W  target address
cmd_wdata  input  DATA_W  write data
cmd_prot  input  3  protection attribute
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  output  DATA_W  read data; 0 for writes and timeouts
rsp_err  output  1  pslverr seen or timeout
rsp_timeout  output  1  transfer aborted by the watchdog
psel  output  1  APB select
penable  output  1  APB enable
paddr  output  ADDR_W  APB address
pwrite  output  1  APB direction
pwdata  output  DATA_W  APB write data; 0 on reads
pprot  output  3  APB protection
prdata  input  DATA_W  APB read data
pready  input  1  APB ready
pslverr  input  1  APB slave error
busy  output  1  state != IDLE

Behaviour:
- Reset, asserted asynchronously at any time including mid-transfer:
  - state=IDLE.
  - All registered outputs 0: psel, penable, paddr, pwrite, pwdata, pprot, rsp_*.
  - Watchdog counter 0.
  - An in-flight transfer is dropped and produces no response.
- FSM states IDLE, SETUP, ACCESS, RESP. cmd_ready=1 only in IDLE (decoded from state).
- IDLE:
  - On cmd_valid, latch command into the APB output registers: paddr, pwrite, pprot, and pwdata (pwdata = cmd_wdata if write, else 0).
  - Next state SETUP.
- SETUP:
  - psel=1, penable=0.
  - Next state ACCESS unconditionally. Clear watchdog counter.
- ACCESS: psel=1, penable=1. Evaluated each cycle in priority order:
  - pready=1:
    - Capture rsp_err=pslverr and rsp_timeout=0.
    - Capture rsp_rdata = prdata on reads, 0 on writes.
    - Next state RESP.
  - pready=0, TIMEOUT_CYC!=0, counter==TIMEOUT_CYC-1:
    - rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - Next state RESP.
  - Otherwise counter+1 (saturating width clog2(TIMEOUT_CYC+1)); stay in ACCESS.
- paddr, pwrite, pwdata and pprot stay constant from SETUP through the last ACCESS cycle (APB stability rule).
- RESP:
  - psel=0, penable=0, rsp_valid=1.
  - Response fields held stable until rsp_ready=1, then IDLE with rsp_valid=0.
  - rsp_ready while not in RESP is ignored.
- Latency with zero wait states: command accepted at edge 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3.
  - With immediate rsp_ready, the next command can be accepted in cycle 4.
  - Each pready=0 cycle adds 1 cycle.
- Only one outstanding transfer. cmd_valid during non-IDLE states is not accepted and must be held by the requester.
- Timeout abort: psel drops in RESP without a completing pready. A late pready/prdata from the slave is ignored.
- paddr/pwrite/pprot keep their last value after the transfer; only psel/penable return to 0.
- busy=1 in SETUP, ACCESS and RESP.

Test Plan:
- Write, zero wait: cmd addr=0x4001_0008, wdata=0xA5A5_1234, pready=1.
  - psel rises in cycle 1, penable in cycle 2.
  - pwdata=0xA5A5_1234 throughout.
  - rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read, 3 wait states: pready low for 3 ACCESS cycles, then high with prdata=0x0000_00FF.
  - penable held for 4 cycles with paddr stable.
  - rsp_rdata=0xFF, rsp_valid in cycle 6.
- Slave error: read with pready=1 and pslverr=1.
  - rsp_err=1, rsp_timeout=0, rsp_rdata=prdata.
- Timeout: TIMEOUT_CYC=4, pready stuck at 0.
  - Exactly 4 ACCESS cycles, then RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0, psel=0.
  - Repeat with TIMEOUT_CYC=0: stays in ACCESS indefinitely.
- Backpressure plus reset: hold rsp_ready=0 for 10 cycles.
  - rsp fields stable and cmd_ready=0 throughout.
  - Assert preset mid-ACCESS of the next transfer: psel, penable and rsp_valid drop immediately; cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// Command/response stream and APB3 bus bundle for apb_cmd_master.
// The master modport is the initiator's view; slave is the requester/peripheral side.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [2:0]        cmd_prot;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [2:0]        pprot;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_prot, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, paddr, pwrite, pwdata, pprot, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_prot, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, paddr, pwrite, pwdata, pprot, busy
  );
endinterface

// File: rtl/apb_cmd_master.sv
// APB3 initiator: turns one valid/ready command into a single APB transfer and
// returns a response word; a wait-state watchdog aborts transfers to hung slaves.
module apb_cmd_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              pclk,
  input  logic              preset,
  apb_cmd_master_if.master  bus
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [2:0]        pprot_q, pprot_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  // Next-state, watchdog and registered-output computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pprot_d       = pprot_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_write ? bus.cmd_wdata : {DATA_W{1'b0}};
          pprot_d  = bus.cmd_prot;
          state_d  = SETUP;
        end else begin
          state_d  = IDLE;
        end
      end
      SETUP: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? {DATA_W{1'b0}} : bus.prdata;
          state_d       = RESP;
        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = {DATA_W{1'b0}};
          state_d       = RESP;
        end else begin
          // Saturate so a disabled watchdog never wraps into a false match.
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
          state_d = ACCESS;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  // State, watchdog and output registers; reset drops any in-flight transfer.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= {ADDR_W{1'b0}};
      pwrite_q      <= 1'b0;
      pwdata_q      <= {DATA_W{1'b0}};
      pprot_q       <= 3'b000;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= {DATA_W{1'b0}};
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pprot       = pprot_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed self-checking bench for apb_cmd_master: one instance with a 4-cycle
// watchdog for the main scenarios and one with the watchdog disabled.
module tb_apb_cmd_master;

  logic pclk;
  logic preset;
  int   checks;
  int   errors;

  apb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) if4 ();
  apb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) if0 ();

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut4 (
    .pclk(pclk), .preset(preset), .bus(if4.master)
  );

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(0)) dut0 (
    .pclk(pclk), .preset(preset), .bus(if0.master)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_inputs();
    if4.cmd_valid = 1'b0; if4.cmd_write = 1'b0; if4.cmd_addr = 32'h0; if4.cmd_wdata = 32'h0;
    if4.cmd_prot = 3'b000; if4.rsp_ready = 1'b0; if4.prdata = 32'h0; if4.pready = 1'b0; if4.pslverr = 1'b0;
    if0.cmd_valid = 1'b0; if0.cmd_write = 1'b0; if0.cmd_addr = 32'h0; if0.cmd_wdata = 32'h0;
    if0.cmd_prot = 3'b000; if0.rsp_ready = 1'b0; if0.prdata = 32'h0; if0.pready = 1'b0; if0.pslverr = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge pclk);
    #1;
    checks++; if (if4.psel !== 1'b0) begin errors++; $display("FAIL rst_psel: got %0h expected 0", if4.psel); end
    checks++; if (if4.penable !== 1'b0) begin errors++; $display("FAIL rst_penable: got %0h expected 0", if4.penable); end
    checks++; if (if4.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %0h expected 0", if4.rsp_valid); end
    checks++; if (if4.paddr !== 32'h0) begin errors++; $display("FAIL rst_paddr: got %0h expected 0", if4.paddr); end
    checks++; if (if4.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0h expected 0", if4.busy); end
    preset = 1'b0;
    tick();
    checks++; if (if4.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %0h expected 1", if4.cmd_ready); end
  endtask

  task automatic test_write_zero_wait();
    if4.cmd_valid = 1'b1; if4.cmd_write = 1'b1; if4.cmd_addr = 32'h4001_0008;
    if4.cmd_wdata = 32'hA5A5_1234; if4.cmd_prot = 3'b010;
    if4.pready = 1'b1; if4.prdata = 32'hDEAD_BEEF; if4.rsp_ready = 1'b0;
    checks++; if (if4.cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_c0_cmd_ready: got %0h expected 1", if4.cmd_ready); end
    tick();
    if4.cmd_valid = 1'b0;
    checks++; if ({if4.psel, if4.penable} !== 2'b10) begin errors++; $display("FAIL wr_c1_psel_penable: got %0b expected 10", {if4.psel, if4.penable}); end
    checks++; if (if4.pwdata !== 32'hA5A5_1234) begin errors++; $display("FAIL wr_c1_pwdata: got %0h expected a5a51234", if4.pwdata); end
    checks++; if ({if4.pwrite, if4.pprot, if4.busy, if4.cmd_ready} !== 6'b1_010_10) begin errors++; $display("FAIL wr_c1_ctrl: got %0b expected 101010", {if4.pwrite, if4.pprot, if4.busy, if4.cmd_ready}); end
    checks++; if (if4.paddr !== 32'h4001_0008) begin errors++; $display("FAIL wr_c1_paddr: got %0h expected 40010008", if4.paddr); end
    tick();
    checks++; if ({if4.psel, if4.penable} !== 2'b11) begin errors++; $display("FAIL wr_c2_psel_penable: got %0b expected 11", {if4.psel, if4.penable}); end
    checks++; if (if4.pwdata !== 32'hA5A5_1234) begin errors++; $display("FAIL wr_c2_pwdata: got %0h expected a5a51234", if4.pwdata); end
    tick();
    checks++; if ({if4.rsp_valid, if4.rsp_err, if4.rsp_timeout, if4.psel, if4.penable} !== 5'b10000) begin errors++; $display("FAIL wr_c3_rsp: got %0b expected 10000", {if4.rsp_valid, if4.rsp_err, if4.rsp_timeout, if4.psel, if4.penable}); end
    checks++; if (if4.rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_c3_rdata: got %0h expected 0", if4.rsp_rdata); end
    checks++; if (if4.paddr !== 32'h4001_0008) begin errors++; $display("FAIL wr_c3_paddr_kept: got %0h expected 40010008", if4.paddr); end
    if4.rsp_ready = 1'b1;
    tick();
    if4.rsp_ready = 1'b0;
    checks++; if ({if4.rsp_valid, if4.cmd_ready} !== 2'b01) begin errors++; $display("FAIL wr_c4_idle: got %0b expected 01", {if4.rsp_valid, if4.cmd_ready}); end
  endtask

  task automatic test_read_wait3();
    if4.cmd_valid = 1'b1; if4.cmd_write = 1'b0; if4.cmd_addr = 32'h4002_0010;
    if4.cmd_wdata = 32'h1111_1111; if4.cmd_prot = 3'b001; if4.pready = 1'b0; if4.prdata = 32'h0;
    tick();
    if4.cmd_valid = 1'b0;
    checks++; if ({if4.psel, if4.penable, if4.pwrite} !== 3'b100) begin errors++; $display("FAIL rd_c1_setup: got %0b expected 100", {if4.psel, if4.penable, if4.pwrite}); end
    checks++; if (if4.pwdata !== 32'h0) begin errors++; $display("FAIL rd_c1_pwdata: got %0h expected 0", if4.pwdata); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({if4.psel, if4.penable, if4.rsp_valid} !== 3'b110) begin errors++; $display("FAIL rd_access%0d: got %0b expected 110", i, {if4.psel, if4.penable, if4.rsp_valid}); end
      checks++; if (if4.paddr !== 32'h4002_0010) begin errors++; $display("FAIL rd_paddr%0d: got %0h expected 40020010", i, if4.paddr); end
      if (i == 3) begin
        if4.pready = 1'b1; if4.prdata = 32'h0000_00FF;
      end
    end
    tick();
    if4.pready = 1'b0;
    checks++; if ({if4.rsp_valid, if4.rsp_err, if4.rsp_timeout, if4.psel} !== 4'b1000) begin errors++; $display("FAIL rd_c6_rsp: got %0b expected 1000", {if4.rsp_valid, if4.rsp_err, if4.rsp_timeout, if4.psel}); end
    checks++; if (if4.rsp_rdata !== 32'h0000_00FF) begin errors++; $display("FAIL rd_c6_rdata: got %0h expected ff", if4.rsp_rdata); end
    if4.rsp_ready = 1'b1;
    tick();
    if4.rsp_ready = 1'b0;
  endtask

  task automatic test_slverr();
    if4.cmd_valid = 1'b1; if4.cmd_write = 1'b0; if4.cmd_addr = 32'h4003_0000;
    if4.pready = 1'b1; if4.pslverr = 1'b1; if4.prdata = 32'h1234_5678;
    tick();
    if4.cmd_valid = 1'b0;
    tick();
    tick();
    if4.pslverr = 1'b0;
    checks++; if ({if4.rsp_valid, if4.rsp_err, if4.rsp_timeout} !== 3'b110) begin errors++; $display("FAIL err_rsp: got %0b expected 110", {if4.rsp_valid, if4.rsp_err, if4.rsp_timeout}); end
    checks++; if (if4.rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL err_rdata: got %0h expected 12345678", if4.rsp_rdata); end
    if4.rsp_ready = 1'b1;
    tick();
    if4.rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    if4.cmd_valid = 1'b1; if4.cmd_write = 1'b0; if4.cmd_addr = 32'h4004_0004;
    if4.pready = 1'b0; if4.prdata = 32'h0;
    tick();
    if4.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({if4.psel, if4.penable, if4.rsp_valid} !== 3'b110) begin errors++; $display("FAIL to_access%0d: got %0b expected 110", i, {if4.psel, if4.penable, if4.rsp_valid}); end
    end
    tick();
    checks++; if ({if4.rsp_valid, if4.rsp_err, if4.rsp_timeout, if4.psel, if4.penable} !== 5'b11100) begin errors++; $display("FAIL to_rsp: got %0b expected 11100", {if4.rsp_valid, if4.rsp_err, if4.rsp_timeout, if4.psel, if4.penable}); end
    checks++; if (if4.rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: got %0h expected 0", if4.rsp_rdata); end
    if4.pready = 1'b1; if4.prdata = 32'h0000_ABCD;
    tick();
    checks++; if ({if4.rsp_valid, if4.rsp_timeout} !== 2'b11 || if4.rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_late_pready: got valid/to %0b rdata %0h expected 11 / 0", {if4.rsp_valid, if4.rsp_timeout}, if4.rsp_rdata); end
    if4.pready = 1'b0; if4.prdata = 32'h0;
    if4.rsp_ready = 1'b1;
    tick();
    if4.rsp_ready = 1'b0;
    checks++; if (if4.cmd_ready !== 1'b1) begin errors++; $display("FAIL to_back_idle: got %0h expected 1", if4.cmd_ready); end
  endtask

  task automatic test_no_timeout();
    int bad;
    bad = 0;
    if0.cmd_valid = 1'b1; if0.cmd_write = 1'b0; if0.cmd_addr = 32'h4005_0000;
    if0.pready = 1'b0; if0.prdata = 32'h0000_0042;
    tick();
    if0.cmd_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if ({if0.psel, if0.penable, if0.rsp_valid} !== 3'b110) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL nto_stuck_access: got %0d bad cycles expected 0", bad); end
    if0.pready = 1'b1;
    tick();
    if0.pready = 1'b0;
    checks++; if ({if0.rsp_valid, if0.rsp_err, if0.rsp_timeout} !== 3'b100 || if0.rsp_rdata !== 32'h42) begin errors++; $display("FAIL nto_rsp: got %0b rdata %0h expected 100 / 42", {if0.rsp_valid, if0.rsp_err, if0.rsp_timeout}, if0.rsp_rdata); end
    if0.rsp_ready = 1'b1;
    tick();
    if0.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back_reset();
    int bad;
    bad = 0;
    if4.cmd_valid = 1'b1; if4.cmd_write = 1'b0; if4.cmd_addr = 32'h4006_0000;
    if4.pready = 1'b1; if4.prdata = 32'h5555_AAAA; if4.rsp_ready = 1'b0;
    tick();
    // Next command is already pending and must be held through backpressure.
    if4.cmd_addr = 32'h4007_000C; if4.cmd_write = 1'b1; if4.cmd_wdata = 32'h0BAD_F00D;
    tick();
    tick();
    if4.pready = 1'b0; if4.prdata = 32'h0;
    for (int i = 0; i < 10; i++) begin
      if ({if4.rsp_valid, if4.rsp_err, if4.rsp_timeout, if4.cmd_ready, if4.psel} !== 5'b10000 || if4.rsp_rdata !== 32'h5555_AAAA) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad); end
    if4.rsp_ready = 1'b1;
    tick();
    if4.rsp_ready = 1'b0;
    checks++; if ({if4.cmd_ready, if4.rsp_valid} !== 2'b10) begin errors++; $display("FAIL bp_release: got %0b expected 10", {if4.cmd_ready, if4.rsp_valid}); end
    tick();
    if4.cmd_valid = 1'b0;
    checks++; if (if4.paddr !== 32'h4007_000C || if4.pwdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL bp_next_setup: got %0h/%0h expected 4007000c/badf00d", if4.paddr, if4.pwdata); end
    tick();
    checks++; if ({if4.psel, if4.penable} !== 2'b11) begin errors++; $display("FAIL bp_next_access: got %0b expected 11", {if4.psel, if4.penable}); end
    #2 preset = 1'b1;
    #1;
    checks++; if ({if4.psel, if4.penable, if4.rsp_valid, if4.busy} !== 4'b0000) begin errors++; $display("FAIL rst_mid_access: got %0b expected 0000", {if4.psel, if4.penable, if4.rsp_valid, if4.busy}); end
    tick();
    preset = 1'b0;
    tick();
    checks++; if ({if4.cmd_ready, if4.rsp_valid, if4.psel} !== 3'b100) begin errors++; $display("FAIL rst_after_release: got %0b expected 100", {if4.cmd_ready, if4.rsp_valid, if4.psel}); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_zero_wait();
    test_read_wait3();
    test_slverr();
    test_timeout();
    test_no_timeout();
    test_back_to_back_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
